// File: rtl/snpu_policy_deck.sv
// Policy-card engine: stack, hand, discard and board tallies, with a multi-cycle Fisher-Yates shuffle.
// Optional build macro SNPU_DECK_ENTROPY_EN adds entropy_in, XORed into LFSR bit 0 every cycle.
module snpu_policy_deck #(
  parameter int          DECK_SIZE = 17,
  parameter int          N_ONES    = 11,
  parameter int          HAND      = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CNT_W     = $clog2(DECK_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_idx,
`ifdef SNPU_DECK_ENTROPY_EN
  input  logic             entropy_in,
`endif
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [7:0]       rsp_data,
  output logic [CNT_W-1:0] n_stack,
  output logic [1:0]       hand_cnt
);

  localparam logic [2:0] OP_NEW_GAME = 3'd1;
  localparam logic [2:0] OP_SHUFFLE  = 3'd2;
  localparam logic [2:0] OP_DRAW     = 3'd3;
  localparam logic [2:0] OP_DISCARD  = 3'd4;
  localparam logic [2:0] OP_ENACT    = 3'd5;
  localparam logic [2:0] OP_PEEK     = 3'd6;
  localparam logic [2:0] OP_STATUS   = 3'd7;

  localparam logic [DECK_SIZE-1:0] STACK_INIT = DECK_SIZE'((64'd1 << N_ONES) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t                 state_q, state_d;
  logic [DECK_SIZE-1:0]   stack_q, stack_d;
  logic [CNT_W-1:0]       n_stack_q, n_stack_d;
  logic [2:0]             hand_q, hand_d;
  logic [1:0]             hand_cnt_q, hand_cnt_d;
  logic [CNT_W-1:0]       disc_ones_q, disc_ones_d;
  logic [CNT_W-1:0]       disc_zeros_q, disc_zeros_d;
  logic [CNT_W-1:0]       board_ones_q, board_ones_d;
  logic [CNT_W-1:0]       board_zeros_q, board_zeros_d;
  logic [CNT_W-1:0]       swap_i_q, swap_i_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             rsp_data_q, rsp_data_d;

  logic [CNT_W:0]         merge_lo, merge_mid, merge_hi;
  logic [CNT_W-1:0]       swap_j;
  logic                   card;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign n_stack   = n_stack_q;
  assign hand_cnt  = hand_cnt_q;

  always_comb begin
    state_d       = state_q;
    stack_d       = stack_q;
    n_stack_d     = n_stack_q;
    hand_d        = hand_q;
    hand_cnt_d    = hand_cnt_q;
    disc_ones_d   = disc_ones_q;
    disc_zeros_d  = disc_zeros_q;
    board_ones_d  = board_ones_q;
    board_zeros_d = board_zeros_q;
    swap_i_d      = swap_i_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_data_d    = 8'h00;

    // Discarded ones land just above the current top, zeros above them.
    merge_lo  = {1'b0, n_stack_q};
    merge_mid = merge_lo + {1'b0, disc_ones_q};
    merge_hi  = merge_mid + {1'b0, disc_zeros_q};
    swap_j    = lfsr_q[CNT_W-1:0];
    card      = hand_q[cmd_idx];

`ifdef SNPU_DECK_ENTROPY_EN
    lfsr_d = lfsr_step(lfsr_q) ^ {15'd0, entropy_in};
`else
    lfsr_d = lfsr_step(lfsr_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rsp_valid_d = 1'b1;
          case (cmd_op)
            OP_NEW_GAME: begin
              stack_d       = STACK_INIT;
              n_stack_d     = CNT_W'(DECK_SIZE);
              hand_d        = '0;
              hand_cnt_d    = '0;
              disc_ones_d   = '0;
              disc_zeros_d  = '0;
              board_ones_d  = '0;
              board_zeros_d = '0;
            end
            OP_SHUFFLE: begin
              if (hand_cnt_q != 2'd0) begin
                rsp_err_d = 1'b1;
              end else begin
                rsp_valid_d = 1'b0;
                state_d     = S_MERGE;
              end
            end
            OP_DRAW: begin
              if (hand_cnt_q != 2'd0 || n_stack_q < CNT_W'(HAND)) begin
                rsp_err_d = 1'b1;
              end else begin
                for (int k = 0; k < 3; k++) begin
                  hand_d[k] = (k < HAND) ? stack_q[n_stack_q - CNT_W'(k + 1)] : 1'b0;
                end
                n_stack_d  = n_stack_q - CNT_W'(HAND);
                hand_cnt_d = 2'(HAND);
                rsp_data_d = {5'd0, hand_d};
              end
            end
            OP_DISCARD, OP_ENACT: begin
              if (cmd_idx >= hand_cnt_q) begin
                rsp_err_d = 1'b1;
              end else begin
                if (cmd_op == OP_DISCARD) begin
                  if (card) disc_ones_d  = disc_ones_q + CNT_W'(1);
                  else      disc_zeros_d = disc_zeros_q + CNT_W'(1);
                end else begin
                  if (card) board_ones_d  = board_ones_q + CNT_W'(1);
                  else      board_zeros_d = board_zeros_q + CNT_W'(1);
                end
                for (int k = 0; k < 2; k++) begin
                  if (2'(k) >= cmd_idx) hand_d[k] = hand_q[k + 1];
                end
                hand_d[2]  = 1'b0;
                hand_cnt_d = hand_cnt_q - 2'd1;
                rsp_data_d = {7'd0, card};
              end
            end
            OP_PEEK: begin
              for (int k = 0; k < 3; k++) begin
                if (n_stack_q > CNT_W'(k)) rsp_data_d[k] = stack_q[n_stack_q - CNT_W'(k + 1)];
              end
            end
            OP_STATUS: rsp_data_d = {4'(board_ones_q), 4'(board_zeros_q)};
            default:   rsp_data_d = 8'h00;
          endcase
        end
      end

      S_MERGE: begin
        for (int k = 0; k < DECK_SIZE; k++) begin
          if ((CNT_W+1)'(k) >= merge_lo && (CNT_W+1)'(k) < merge_mid)
            stack_d[k] = 1'b1;
          else if ((CNT_W+1)'(k) >= merge_mid && (CNT_W+1)'(k) < merge_hi)
            stack_d[k] = 1'b0;
        end
        n_stack_d    = merge_hi[CNT_W-1:0];
        disc_ones_d  = '0;
        disc_zeros_d = '0;
        if (merge_hi <= (CNT_W+1)'(1)) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'(merge_hi);
        end else begin
          state_d  = S_SWAP;
          swap_i_d = merge_hi[CNT_W-1:0] - CNT_W'(1);
        end
      end

      S_SWAP: begin
        // Out-of-range draws of j are retried on the next LFSR value.
        if (swap_j <= swap_i_q) begin
          stack_d[swap_i_q] = stack_q[swap_j];
          stack_d[swap_j]   = stack_q[swap_i_q];
          swap_i_d          = swap_i_q - CNT_W'(1);
          if (swap_i_q == CNT_W'(1)) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'(n_stack_q);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stack_q       <= STACK_INIT;
      n_stack_q     <= CNT_W'(DECK_SIZE);
      hand_q        <= '0;
      hand_cnt_q    <= '0;
      disc_ones_q   <= '0;
      disc_zeros_q  <= '0;
      board_ones_q  <= '0;
      board_zeros_q <= '0;
      swap_i_q      <= '0;
      lfsr_q        <= LFSR_SEED;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      stack_q       <= stack_d;
      n_stack_q     <= n_stack_d;
      hand_q        <= hand_d;
      hand_cnt_q    <= hand_cnt_d;
      disc_ones_q   <= disc_ones_d;
      disc_zeros_q  <= disc_zeros_d;
      board_ones_q  <= board_ones_d;
      board_zeros_q <= board_zeros_d;
      swap_i_q      <= swap_i_d;
      lfsr_q        <= lfsr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

endmodule
